// File: rtl/iq_dur_avg.sv
// Consumer side of the IQ residency-duration monitor: per-class epoch accumulation
// followed by two serial restoring divisions that produce the fast/slow mean report.
module iq_dur_avg #(
    parameter  int DUR_W     = 10,
    parameter  int EPOCH_LEN = 64,
    localparam int CNT_W     = $clog2(EPOCH_LEN + 1),
    localparam int SUM_W     = DUR_W + CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dur_valid,
    output logic             dur_ready,
    input  logic             dur_is_fast,
    input  logic [DUR_W-1:0] dur_value,
    input  logic             epoch_flush,
    output logic             avg_valid,
    input  logic             avg_ready,
    output logic [DUR_W-1:0] avg_fast,
    output logic [DUR_W-1:0] avg_slow,
    output logic [CNT_W-1:0] cnt_fast,
    output logic [CNT_W-1:0] cnt_slow,
    output logic             fast_empty,
    output logic             slow_empty
);

    localparam int DC_W = (SUM_W > 1) ? $clog2(SUM_W) : 1;

    typedef enum logic [1:0] {
        ACCUM,
        DIV_FAST,
        DIV_SLOW,
        REPORT
    } state_t;

    state_t state, state_nxt;

    logic [SUM_W-1:0] sum_fast, sum_slow;
    logic [CNT_W-1:0] acc_cnt_fast, acc_cnt_slow;

    // Divider: dvd shifts left, quotient bits enter at the LSB, so after SUM_W
    // steps dvd holds the quotient.
    logic [SUM_W-1:0] dvd;
    logic [CNT_W-1:0] dvs;
    logic [CNT_W:0]   rem;
    logic [DC_W-1:0]  bit_idx;
    logic [DUR_W-1:0] q_fast_hold;

    logic             accept;
    logic             close;
    logic [CNT_W:0]   total_nxt;
    logic [SUM_W-1:0] sum_fast_nxt, sum_slow_nxt;
    logic [CNT_W-1:0] cnt_fast_nxt, cnt_slow_nxt;
    logic [CNT_W+1:0] rem_shift, rem_diff;
    logic             take;
    logic [CNT_W:0]   rem_nxt;
    logic [SUM_W-1:0] dvd_nxt;
    logic             last_bit;

    always_comb begin
        accept       = (state == ACCUM) && dur_valid;
        sum_fast_nxt = sum_fast;
        sum_slow_nxt = sum_slow;
        cnt_fast_nxt = acc_cnt_fast;
        cnt_slow_nxt = acc_cnt_slow;
        if (accept && dur_is_fast) begin
            sum_fast_nxt = sum_fast + SUM_W'(dur_value);
            cnt_fast_nxt = acc_cnt_fast + CNT_W'(1);
        end
        if (accept && !dur_is_fast) begin
            sum_slow_nxt = sum_slow + SUM_W'(dur_value);
            cnt_slow_nxt = acc_cnt_slow + CNT_W'(1);
        end
        total_nxt = {1'b0, cnt_fast_nxt} + {1'b0, cnt_slow_nxt};
        close     = (state == ACCUM) &&
                    (epoch_flush || (accept && (total_nxt == (CNT_W+1)'(EPOCH_LEN))));
    end

    // Borrow out of rem_diff means the shifted remainder is below the divisor;
    // a zero divisor never takes, which forces a zero quotient.
    always_comb begin
        rem_shift = {rem, dvd[SUM_W-1]};
        rem_diff  = rem_shift - {2'b00, dvs};
        take      = (dvs != '0) && !rem_diff[CNT_W+1];
        rem_nxt   = take ? rem_diff[CNT_W:0] : rem_shift[CNT_W:0];
        dvd_nxt   = {dvd[SUM_W-2:0], take};
        last_bit  = (bit_idx == DC_W'(SUM_W - 1));
    end

    always_comb begin
        state_nxt = state;
        dur_ready = 1'b0;
        avg_valid = 1'b0;
        case (state)
            ACCUM: begin
                dur_ready = 1'b1;
                if (close) state_nxt = DIV_FAST;
            end
            DIV_FAST: begin
                if (last_bit) state_nxt = DIV_SLOW;
            end
            DIV_SLOW: begin
                if (last_bit) state_nxt = REPORT;
            end
            REPORT: begin
                avg_valid = 1'b1;
                if (avg_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ACCUM;
            sum_fast     <= '0;
            sum_slow     <= '0;
            acc_cnt_fast <= '0;
            acc_cnt_slow <= '0;
            dvd          <= '0;
            dvs          <= '0;
            rem          <= '0;
            bit_idx      <= '0;
            q_fast_hold  <= '0;
            avg_fast     <= '0;
            avg_slow     <= '0;
            cnt_fast     <= '0;
            cnt_slow     <= '0;
            fast_empty   <= 1'b1;
            slow_empty   <= 1'b1;
        end else begin
            state <= state_nxt;
            case (state)
                ACCUM: begin
                    sum_fast     <= sum_fast_nxt;
                    sum_slow     <= sum_slow_nxt;
                    acc_cnt_fast <= cnt_fast_nxt;
                    acc_cnt_slow <= cnt_slow_nxt;
                    if (close) begin
                        dvd     <= sum_fast_nxt;
                        dvs     <= cnt_fast_nxt;
                        rem     <= '0;
                        bit_idx <= '0;
                    end
                end
                DIV_FAST: begin
                    dvd     <= dvd_nxt;
                    rem     <= rem_nxt;
                    bit_idx <= bit_idx + DC_W'(1);
                    if (last_bit) begin
                        q_fast_hold <= dvd_nxt[DUR_W-1:0];
                        dvd         <= sum_slow;
                        dvs         <= acc_cnt_slow;
                        rem         <= '0;
                        bit_idx     <= '0;
                    end
                end
                DIV_SLOW: begin
                    dvd     <= dvd_nxt;
                    rem     <= rem_nxt;
                    bit_idx <= bit_idx + DC_W'(1);
                    // Report registers change only here so they stay stable between reports.
                    if (last_bit) begin
                        avg_fast   <= q_fast_hold;
                        avg_slow   <= dvd_nxt[DUR_W-1:0];
                        cnt_fast   <= acc_cnt_fast;
                        cnt_slow   <= acc_cnt_slow;
                        fast_empty <= (acc_cnt_fast == '0);
                        slow_empty <= (acc_cnt_slow == '0);
                    end
                end
                REPORT: begin
                    if (avg_ready) begin
                        sum_fast     <= '0;
                        sum_slow     <= '0;
                        acc_cnt_fast <= '0;
                        acc_cnt_slow <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_dur_avg.sv
// Self-checking bench for iq_dur_avg: directed epochs plus random epochs compared
// against a queue-based mean model, and a small EPOCH_LEN=4 instance.
module tb_iq_dur_avg;

    localparam int DUR_W     = 10;
    localparam int EPOCH_LEN = 64;
    localparam int CNT_W     = 7;
    localparam int SUM_W     = DUR_W + CNT_W;
    localparam int LAT       = 2 * SUM_W + 1;
    localparam int CNT4_W    = 3;
    localparam int LAT4      = 2 * (DUR_W + CNT4_W) + 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             dur_valid, dur_ready, dur_is_fast, epoch_flush;
    logic [DUR_W-1:0] dur_value;
    logic             avg_valid, avg_ready;
    logic [DUR_W-1:0] avg_fast, avg_slow;
    logic [CNT_W-1:0] cnt_fast, cnt_slow;
    logic             fast_empty, slow_empty;

    logic              d4_valid, d4_ready, d4_is_fast, d4_flush;
    logic [DUR_W-1:0]  d4_value;
    logic              d4_avg_valid;
    logic [DUR_W-1:0]  d4_avg_fast, d4_avg_slow;
    logic [CNT4_W-1:0] d4_cnt_fast, d4_cnt_slow;
    logic              d4_fast_empty, d4_slow_empty;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int close_cyc   = 0;
    int q_fast[$];
    int q_slow[$];

    iq_dur_avg #(.DUR_W(DUR_W), .EPOCH_LEN(EPOCH_LEN)) dut (
        .clk(clk), .reset_n(reset_n),
        .dur_valid(dur_valid), .dur_ready(dur_ready), .dur_is_fast(dur_is_fast),
        .dur_value(dur_value), .epoch_flush(epoch_flush),
        .avg_valid(avg_valid), .avg_ready(avg_ready),
        .avg_fast(avg_fast), .avg_slow(avg_slow),
        .cnt_fast(cnt_fast), .cnt_slow(cnt_slow),
        .fast_empty(fast_empty), .slow_empty(slow_empty)
    );

    iq_dur_avg #(.DUR_W(DUR_W), .EPOCH_LEN(4)) d4 (
        .clk(clk), .reset_n(reset_n),
        .dur_valid(d4_valid), .dur_ready(d4_ready), .dur_is_fast(d4_is_fast),
        .dur_value(d4_value), .epoch_flush(d4_flush),
        .avg_valid(d4_avg_valid), .avg_ready(1'b1),
        .avg_fast(d4_avg_fast), .avg_slow(d4_avg_slow),
        .cnt_fast(d4_cnt_fast), .cnt_slow(d4_cnt_slow),
        .fast_empty(d4_fast_empty), .slow_empty(d4_slow_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_avg(input bit fast);
        int s = 0;
        int n = fast ? q_fast.size() : q_slow.size();
        for (int i = 0; i < n; i++) s += fast ? q_fast[i] : q_slow[i];
        return (n == 0) ? 0 : s / n;
    endfunction

    // Drives one cycle in ACCUM; the model records the sample and whether the epoch closes.
    task automatic applyStimulus(input bit valid, input bit fast, input int value, input bit flush);
        @(negedge clk);
        check("dur_ready_accum", dur_ready, 1);
        dur_valid   = valid;
        dur_is_fast = fast;
        dur_value   = DUR_W'(value);
        epoch_flush = flush;
        if (valid) begin
            if (fast) q_fast.push_back(value);
            else      q_slow.push_back(value);
        end
        if (flush || (q_fast.size() + q_slow.size() == EPOCH_LEN)) close_cyc = cyc;
        @(posedge clk);
        #1;
        dur_valid   = 1'b0;
        epoch_flush = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        int waited = 0;
        @(negedge clk);
        while (avg_valid !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"},   avg_valid, 1);
        check({tag, "_latency"}, cyc - close_cyc, LAT);
        check({tag, "_avg_fast"}, avg_fast, model_avg(1));
        check({tag, "_avg_slow"}, avg_slow, model_avg(0));
        check({tag, "_cnt_fast"}, cnt_fast, q_fast.size());
        check({tag, "_cnt_slow"}, cnt_slow, q_slow.size());
        check({tag, "_fast_empty"}, fast_empty, q_fast.size() == 0);
        check({tag, "_slow_empty"}, slow_empty, q_slow.size() == 0);
    endtask

    task automatic ackReport();
        avg_ready = 1'b1;
        @(negedge clk);
        check("post_ack_valid", avg_valid, 0);
        check("post_ack_ready", dur_ready, 1);
        q_fast.delete();
        q_slow.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_avg_valid"}, avg_valid, 0);
        check({tag, "_avg_fast"}, avg_fast, 0);
        check({tag, "_avg_slow"}, avg_slow, 0);
        check({tag, "_cnt_fast"}, cnt_fast, 0);
        check({tag, "_cnt_slow"}, cnt_slow, 0);
        check({tag, "_fast_empty"}, fast_empty, 1);
        check({tag, "_slow_empty"}, slow_empty, 1);
    endtask

    initial begin
        int len;
        int seen;
        int d4_vals[4];
        bit d4_cls[4];
        reset_n = 1'b0; dur_valid = 1'b0; dur_is_fast = 1'b0; dur_value = '0;
        epoch_flush = 1'b0; avg_ready = 1'b1;
        d4_valid = 1'b0; d4_is_fast = 1'b0; d4_value = '0; d4_flush = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_release_ready", dur_ready, 1);

        // Interleaved 32 fast of 100 and 32 slow of 300, closed by count.
        for (int i = 0; i < 64; i++) applyStimulus(1, i % 2 == 0, (i % 2 == 0) ? 100 : 300, 0);
        checkOutput("interleave");
        ackReport();

        for (int i = 0; i < 64; i++) applyStimulus(1, 1, 1023, 0);
        checkOutput("all_fast_max");
        ackReport();

        for (int i = 1; i <= 5; i++) applyStimulus(1, 1, 10 * i, i == 5);
        checkOutput("flush_with_last");
        ackReport();

        applyStimulus(0, 0, 0, 1);
        checkOutput("empty_flush");
        ackReport();

        for (int e = 0; e < 4; e++) begin
            len = $urandom_range(1, EPOCH_LEN);
            for (int i = 0; i < len; i++)
                applyStimulus(1, 1'($urandom_range(0, 1)), $urandom_range(0, 1023),
                              (i == len - 1) && (len < EPOCH_LEN));
            checkOutput("random_epoch");
            ackReport();
        end

        // Report held: inputs offered during the stall must be ignored.
        avg_ready = 1'b0;
        applyStimulus(1, 1, 40, 0);
        applyStimulus(1, 0, 900, 1);
        checkOutput("hold");
        for (int i = 0; i < 10; i++) begin
            dur_valid = 1'b1; dur_is_fast = 1'b1; dur_value = 10'd555; epoch_flush = 1'b1;
            @(negedge clk);
            check("hold_valid", avg_valid, 1);
            check("hold_ready", dur_ready, 0);
            check("hold_avg_fast", avg_fast, model_avg(1));
            check("hold_avg_slow", avg_slow, model_avg(0));
        end
        dur_valid = 1'b0; epoch_flush = 1'b0;
        ackReport();
        applyStimulus(1, 1, 7, 1);
        checkOutput("after_hold");
        ackReport();

        // Reset in the middle of the slow division discards the epoch.
        applyStimulus(1, 1, 50, 0);
        applyStimulus(1, 0, 60, 1);
        repeat (24) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checkResetOutputs("mid_div_reset");
        check("mid_div_reset_ready", dur_ready, 1);
        q_fast.delete();
        q_slow.delete();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (avg_valid !== 1'b0) seen++;
        end
        check("reset_no_report", seen, 0);
        for (int i = 0; i < 9; i++) applyStimulus(1, 1'($urandom_range(0, 1)), $urandom_range(0, 1023), i == 8);
        checkOutput("post_reset_epoch");
        ackReport();

        // EPOCH_LEN=4 instance closes on its own after the fourth sample.
        d4_cls  = '{1, 1, 0, 0};
        d4_vals = '{1, 2, 1023, 1022};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("d4_ready", d4_ready, 1);
            d4_valid = 1'b1; d4_is_fast = d4_cls[i]; d4_value = DUR_W'(d4_vals[i]);
            if (i == 3) close_cyc = cyc;
        end
        @(negedge clk);
        d4_valid = 1'b0;
        seen = 1;
        while (d4_avg_valid !== 1'b1 && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        check("d4_latency", cyc - close_cyc, LAT4);
        check("d4_avg_fast", d4_avg_fast, 1);
        check("d4_avg_slow", d4_avg_slow, 1022);
        check("d4_cnt_fast", d4_cnt_fast, 2);
        check("d4_cnt_slow", d4_cnt_slow, 2);
        check("d4_empty", {d4_fast_empty, d4_slow_empty}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
